// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, sequencer FSM encoding and the
// Nr/Nk consistency helper used at elaboration.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  function automatic int nr_for_nk(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_round_key_mux.sv
// Selects the 128-bit round key for round_idx out of the expanded-key bus.
// Key 0 sits in the most significant 128 bits.
module aes_round_key_mux
  import aes_pkg::*;
#(
  parameter int Nr = 10
) (
  input  logic [AES_BLOCK_W*(Nr+1)-1:0] all_keys,
  input  logic [$clog2(Nr+1)-1:0]       round_idx,
  output logic [AES_BLOCK_W-1:0]        round_key
);

  always_comb begin
    // NOTE: default assignment first so no path through the block can infer a latch.
    round_key = '0;
    for (int r = 0; r <= Nr; r++) begin
      if (int'(round_idx) == r) begin
        round_key = all_keys[AES_BLOCK_W*(Nr+1-r)-1 -: AES_BLOCK_W];
      end
    end
  end

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES round sequencer: key-0 whitening on accept, Nr datapath steps,
// then holds the ciphertext until acknowledged. AES_SCHED_ABORT_EN adds `abort`.
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef AES_SCHED_ABORT_EN
  input  logic                          abort,
`endif
  input  logic                          start,
  input  logic [AES_BLOCK_W-1:0]        msg_in,
  input  logic [AES_BLOCK_W*(Nr+1)-1:0] all_keys,
  output logic [AES_BLOCK_W-1:0]        round_state,
  output logic [AES_BLOCK_W-1:0]        round_key,
  output logic [$clog2(Nr+1)-1:0]       round_idx,
  output logic                          last_round,
  input  logic [AES_BLOCK_W-1:0]        round_result,
  output logic                          busy,
  output logic [AES_BLOCK_W-1:0]        ct_out,
  output logic                          ct_valid,
  input  logic                          ct_ack
);

  localparam int              IW       = $clog2(Nr+1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(Nr);

  if (Nr != nr_for_nk(Nk)) begin : g_param_check
    $error("aes_round_sched: Nr must equal Nk+6");
  end

  aes_state_e             fsm;
  logic [AES_BLOCK_W-1:0] state_reg;
  logic [IW-1:0]          idx;
  logic [AES_BLOCK_W-1:0] key0;

  assign key0 = all_keys[AES_BLOCK_W*(Nr+1)-1 -: AES_BLOCK_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the state register is a plain 128-bit register, not a memory, so it
      // is reset like any other flop; ct_out must read zero out of reset.
      fsm       <= ST_IDLE;
      state_reg <= '0;
      idx       <= '0;
    end else begin
`ifdef AES_SCHED_ABORT_EN
      if (abort) begin
        // Abort wins over start/ct_ack; in IDLE it only swallows a start.
        if (fsm != ST_IDLE) begin
          fsm       <= ST_IDLE;
          state_reg <= '0;
          idx       <= '0;
        end
      end else
`endif
      begin
        // NOTE: non-blocking assignments keep every register update on the
        // same edge independent of statement order.
        unique case (fsm)
          ST_IDLE: begin
            if (start) begin
              state_reg <= msg_in ^ key0;
              idx       <= IW'(1);
              fsm       <= ST_ROUND;
            end
          end
          ST_ROUND: begin
            state_reg <= round_result;
            if (idx == LAST_IDX) begin
              fsm <= ST_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          ST_DONE: begin
            // ack+start together accepts the next block without an IDLE bubble.
            if (ct_ack && start) begin
              state_reg <= msg_in ^ key0;
              idx       <= IW'(1);
              fsm       <= ST_ROUND;
            end else if (ct_ack) begin
              fsm <= ST_IDLE;
            end
          end
          default: fsm <= ST_IDLE;
        endcase
      end
    end
  end

  aes_round_key_mux #(
    .Nr (Nr)
  ) u_key_mux (
    .all_keys  (all_keys),
    .round_idx (idx),
    .round_key (round_key)
  );

  assign round_state = state_reg;
  assign round_idx   = idx;
  assign last_round  = (idx == LAST_IDX);
  assign busy        = (fsm == ST_ROUND);
  assign ct_valid    = (fsm == ST_DONE);
  assign ct_out      = state_reg;

endmodule

// File: tb/tb_aes_round_sched.sv
// Scoreboard bench for aes_round_sched: Nr=10 and Nr=14 instances, each closed
// with a reference AES round model; checks FIPS-197 ciphertexts and timing.
module tb_aes_round_sched;

  typedef struct {
    logic [127:0] ct;
    int           acc_edge;
  } exp_t;

  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference AES model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    if (x == 8'h00) inv = 8'h00;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  // Up to 60 expanded words, key 0 in the MS bits.
  function automatic logic [1919:0] expand_key(input int nk, input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] o;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      o[1919-32*i -: 32] = w[i];
    end
    return o;
  endfunction

  // ---------------- DUT signals ----------------
  logic          start10 = 1'b0, ack10 = 1'b0, abort10 = 1'b0;
  logic [127:0]  msg10 = '0;
  logic [1407:0] keys10;
  logic [127:0]  rs10, rk10, rr10, ct10;
  logic [3:0]    idx10;
  logic          lr10, busy10, cv10;

  logic          start14 = 1'b0, ack14 = 1'b0, abort14 = 1'b0;
  logic [127:0]  msg14 = '0;
  logic [1919:0] keys14;
  logic [127:0]  rs14, rk14, rr14, ct14;
  logic [3:0]    idx14;
  logic          lr14, busy14, cv14;

  logic [1919:0] full_c1, full_b;

  always_comb rr10 = aes_round(rs10, rk10, lr10);
  always_comb rr14 = aes_round(rs14, rk14, lr14);

  aes_round_sched #(.Nr(10), .Nk(4)) u_dut10 (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef AES_SCHED_ABORT_EN
    .abort        (abort10),
`endif
    .start        (start10),
    .msg_in       (msg10),
    .all_keys     (keys10),
    .round_state  (rs10),
    .round_key    (rk10),
    .round_idx    (idx10),
    .last_round   (lr10),
    .round_result (rr10),
    .busy         (busy10),
    .ct_out       (ct10),
    .ct_valid     (cv10),
    .ct_ack       (ack10)
  );

  aes_round_sched #(.Nr(14), .Nk(8)) u_dut14 (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef AES_SCHED_ABORT_EN
    .abort        (abort14),
`endif
    .start        (start14),
    .msg_in       (msg14),
    .all_keys     (keys14),
    .round_state  (rs14),
    .round_key    (rk14),
    .round_idx    (idx14),
    .last_round   (lr14),
    .round_result (rr14),
    .busy         (busy14),
    .ct_out       (ct14),
    .ct_valid     (cv14),
    .ct_ack       (ack14)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- scoreboard monitors ----------------
  exp_t         exp10[$], exp14[$];
  exp_t         e10, e14;
  logic         cv10_q = 1'b0, cv14_q = 1'b0;
  logic [127:0] held10, held14;
  int           bcnt10 = 0, bcnt14 = 0;

  always @(negedge clk) begin
    if (busy10) bcnt10++;
    else if (!cv10) bcnt10 = 0;
    if (cv10 && !cv10_q) begin
      check("ct10_expected", 128'(exp10.size() != 0), 128'(1));
      if (exp10.size() != 0) begin
        e10 = exp10.pop_front();
        check("ct10_value", ct10, e10.ct);
        check("ct10_latency", 128'(cyc), 128'(e10.acc_edge + 10));
        check("busy10_cycles", 128'(bcnt10), 128'(10));
        held10 = e10.ct;
      end
      bcnt10 = 0;
    end else if (cv10) begin
      check("ct10_held", ct10, held10);
    end
    cv10_q = cv10;
  end

  always @(negedge clk) begin
    if (busy14) bcnt14++;
    else if (!cv14) bcnt14 = 0;
    if (cv14 && !cv14_q) begin
      check("ct14_expected", 128'(exp14.size() != 0), 128'(1));
      if (exp14.size() != 0) begin
        e14 = exp14.pop_front();
        check("ct14_value", ct14, e14.ct);
        check("ct14_latency", 128'(cyc), 128'(e14.acc_edge + 14));
        check("busy14_cycles", 128'(bcnt14), 128'(14));
        held14 = e14.ct;
      end
      bcnt14 = 0;
    end else if (cv14) begin
      check("ct14_held", ct14, held14);
    end
    cv14_q = cv14;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int nr, input logic [127:0] msg, input logic ack,
                       input logic push, input logic [127:0] exp_ct);
    @(negedge clk);
    if (nr == 10) begin
      start10 = 1'b1; ack10 = ack; msg10 = msg;
      if (push) exp10.push_back('{exp_ct, cyc + 1});
    end else begin
      start14 = 1'b1; ack14 = ack; msg14 = msg;
      if (push) exp14.push_back('{exp_ct, cyc + 1});
    end
    @(negedge clk);
    start10 = 1'b0; ack10 = 1'b0; start14 = 1'b0; ack14 = 1'b0;
    msg10 = '1; msg14 = '1;
  endtask

  task automatic ack_only(input int nr);
    @(negedge clk);
    if (nr == 10) ack10 = 1'b1; else ack14 = 1'b1;
    @(negedge clk);
    ack10 = 1'b0; ack14 = 1'b0;
    check("ack_returns_idle", 128'(nr == 10 ? cv10 : cv14), 128'(0));
  endtask

  task automatic wait_valid(input int nr, input int budget);
    for (int i = 0; i < budget && !(nr == 10 ? cv10 : cv14); i++) @(negedge clk);
    check("ct_valid_reached", 128'(nr == 10 ? cv10 : cv14), 128'(1));
  endtask

  task automatic wait_idx10(input logic [3:0] target, input int budget);
    for (int i = 0; i < budget && idx10 != target; i++) @(negedge clk);
    check("round_idx10_reached", 128'(idx10), 128'(target));
  endtask

  task automatic check_reset_outputs10();
    check("rst_ct_valid", 128'(cv10), 128'(0));
    check("rst_busy", 128'(busy10), 128'(0));
    check("rst_ct_out", ct10, 128'(0));
    check("rst_round_idx", 128'(idx10), 128'(0));
    check("rst_last_round", 128'(lr10), 128'(0));
    check("rst_round_key0", rk10, keys10[1407 -: 128]);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    full_c1 = expand_key(4, KEY_C1);
    full_b  = expand_key(4, KEY_B);
    keys10  = full_c1[1919 -: 1408];
    keys14  = expand_key(8, KEY_C3);

    repeat (2) @(negedge clk);
    check_reset_outputs10();
    check("rst_ct_valid14", 128'(cv14), 128'(0));
    rst_n = 1'b1;

    // C.1 with ignored starts mid-round and in DONE
    issue(10, PT_C, 1'b0, 1'b1, CT_C1);
    wait_idx10(4'd5, 20);
    check("round_key_idx5", rk10, keys10[128*6-1 -: 128]);
    check("busy_mid", 128'(busy10), 128'(1));
    issue(10, PT_B, 1'b0, 1'b0, '0);
    wait_valid(10, 20);
    check("last_round_done", 128'(lr10), 128'(1));
    check("round_idx_done", 128'(idx10), 128'(10));
    issue(10, PT_B, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    check("done_no_restart_valid", 128'(cv10), 128'(1));
    check("done_no_restart_busy", 128'(busy10), 128'(0));
    check("done_ct_unchanged", ct10, CT_C1);

    // back-to-back: ack+start with FIPS-197 appendix B block
    @(negedge clk);
    keys10 = full_b[1919 -: 1408];
    start10 = 1'b1; ack10 = 1'b1; msg10 = PT_B;
    exp10.push_back('{CT_B, cyc + 1});
    @(negedge clk);
    start10 = 1'b0; ack10 = 1'b0; msg10 = '1;
    check("b2b_valid_drop", 128'(cv10), 128'(0));
    check("b2b_busy", 128'(busy10), 128'(1));
    wait_valid(10, 20);
    ack_only(10);
    keys10 = full_c1[1919 -: 1408];

    // reset at round_idx 3, block lost
    issue(10, PT_C, 1'b0, 1'b0, '0);
    wait_idx10(4'd3, 20);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs10();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 128'(busy10), 128'(0));
    issue(10, PT_C, 1'b0, 1'b1, CT_C1);
    wait_valid(10, 20);
    ack_only(10);

`ifdef AES_SCHED_ABORT_EN
    issue(10, PT_C, 1'b0, 1'b0, '0);
    wait_idx10(4'd7, 20);
    abort10 = 1'b1;
    @(negedge clk);
    abort10 = 1'b0;
    check("abort_busy", 128'(busy10), 128'(0));
    check("abort_idx", 128'(idx10), 128'(0));
    check("abort_state", rs10, 128'(0));
    repeat (15) @(negedge clk);
    check("abort_no_valid", 128'(cv10), 128'(0));
    @(negedge clk);
    abort10 = 1'b1; start10 = 1'b1; msg10 = PT_C;
    @(negedge clk);
    abort10 = 1'b0; start10 = 1'b0;
    check("abort_idle_drops_start", 128'(busy10), 128'(0));
    issue(10, PT_C, 1'b0, 1'b1, CT_C1);
    wait_valid(10, 20);
    ack_only(10);
`endif

    // AES-256, FIPS-197 C.3
    issue(14, PT_C, 1'b0, 1'b1, CT_C3);
    wait_valid(14, 30);
    check("last_round14", 128'(lr14), 128'(1));
    ack_only(14);

    repeat (3) @(negedge clk);
    check("sb10_drained", 128'(exp10.size()), 128'(0));
    check("sb14_drained", 128'(exp14.size()), 128'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
